fwd_bypass_unit: RTL
====================

Name: fwd_bypass_unit

Overview:
Parametrised operand-forwarding unit for the EX stage of the pipelined CPU.
- Tracks in-flight destination tags internally; no external forwarding-control block is needed.
- Computes per-operand bypass selects at ID and registers them into EX.
- Muxes EX operands from the register file or any of DEPTH downstream stages.
- Detects load-use hazards, raises a stall, and counts stall cycles.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction
DEPTH, 2, bypass sources after EX (1 = MEM, 2 = WB, 3 = WB+1 ...)
SEL_W, 2, select width; must satisfy 2^SEL_W > DEPTH
CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
id_valid_i  in  1  instruction present in ID
id_rs_addr_i  in  NUM_SRC*ADDR_W  ID source registers; slice s is operand s
id_rd_addr_i  in  ADDR_W  ID destination register
id_reg_write_i  in  1  ID instruction writes rd
id_mem_read_i  in  1  ID instruction is a load
flush_i  in  1  squash the instruction leaving ID
ex_rf_data_i  in  NUM_SRC*DW  register-file operands held in ID/EX
byp_data_i  in  DEPTH*DW  slice j = result of stage j+1 (slice 0 MEM ALU result, slice 1 WB write data)
ex_operand_o  out  NUM_SRC*DW  forwarded EX operands
ex_fwd_sel_o  out  NUM_SRC*SEL_W  registered selects; 0 = RF, k = byp slice k-1
stall_o  out  1  load-use hazard: hold PC and IF/ID
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Tag pipe: entries 0..DEPTH-1, entry 0 = EX, entry k = k stages after EX. Each entry holds {valid, reg_write, mem_read, rd}.
- Every cycle, entry k moves to entry k+1 and entry DEPTH-1 is discarded. Downstream stages never stall.
- Entry 0 load rule:
  - Loaded from the ID fields when id_valid_i & ~stall_o & ~flush_i.
  - Otherwise loaded with a bubble (all zeros).
- Match(s,k) = entry k valid & reg_write & rd != 0 & rd == id_rs_addr_i[s], evaluated for k = 0..DEPTH-1.
- Priority: the lowest k wins (youngest producer).
- Next-cycle select for operand s:
  - k+1 for the winning k;
  - 0 if no entry matches;
  - 0 if id_rs_addr_i[s] == 0.
- Load-use: stall_o = id_valid_i & ~flush_i & any s with winning k == 0 and entry 0 mem_read. stall_o is combinational.
- Registered selects sel_q:
  - On an advance cycle, sel_q <= computed selects.
  - On a stall or flush cycle, sel_q <= 0 (bubble enters EX).
- After a one-cycle stall the load sits at entry 1, so the dependent instruction gets select 2 (WB data).
- ex_operand_o[s] is combinational:
  - sel_q[s] == 0 → ex_rf_data_i[s];
  - sel_q[s] == k → byp_data_i slice k-1;
  - sel_q[s] > DEPTH → ex_rf_data_i[s].
- ex_fwd_sel_o = sel_q.
- Counter: stall_cnt_o increments on each cycle with stall_o = 1 and saturates at 2^CNT_W-1. It never wraps.
- flush_i together with a hazard: flush wins; stall_o = 0 and no count.
- Reset:
  - All tag entries become invalid; sel_q = 0; stall_cnt_o = 0.
  - Hence stall_o = 0 and ex_operand_o = ex_rf_data_i from the first post-reset cycle.
  - Reset mid-stall drops the hazard immediately.
- Latency: one cycle from ID decode to the EX select; zero cycles from data inputs to ex_operand_o.

Test Plan:
- RAW distance 1: add r3 then sub r1 = r3 - r2 → next cycle ex_fwd_sel_o[0] = 1; byp_data_i slice 0 = 0x000000AA → ex_operand_o[0] = 0x000000AA; stall_o = 0.
- RAW distance 2: add r3, nop, or using r3 as rt → ex_fwd_sel_o[1] = 2; operand = WB data 0x12345678.
- Double producer: add r5 (0x11) then sub r5 (0x22), then and using r5 → selects MEM slice, operand = 0x22.
- Load-use: lw r4 then add r6 = r4 + r4 → stall_o = 1 for exactly one cycle; stall_cnt_o = 1; EX gets a bubble; next cycle both selects = 2 and operands = WB load data 0xDEADBEEF.
- r0 and flush:
  - addi r0 followed by a user of r0 → select 0.
  - Instruction writing r7 with flush_i = 1, then a user of r7 → select 0.
  - Load-use pair with flush_i = 1 → stall_o = 0.
- Reset and saturation:
  - Assert rst_i during a stall → next cycle stall_o = 0, selects 0, count 0.
  - With CNT_W = 4, force 20 stalls → stall_cnt_o = 15.

Source files
------------

// File: rtl/fwd_bypass_unit.sv
// Operand-forwarding unit for the EX stage.
// Keeps a small pipe of in-flight destination tags, picks the youngest
// producer for each ID source operand, registers that choice into EX and
// muxes the EX operands. A load feeding the very next instruction raises
// a one-cycle stall, which is counted in a saturating counter.
module fwd_bypass_unit #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       id_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0]  id_rs_addr_i,
   input  logic [ADDR_W-1:0]          id_rd_addr_i,
   input  logic                       id_reg_write_i,
   input  logic                       id_mem_read_i,
   input  logic                       flush_i,
   input  logic [NUM_SRC*DATA_W-1:0]  ex_rf_data_i,
   input  logic [DEPTH*DATA_W-1:0]    byp_data_i,
   output logic [NUM_SRC*DATA_W-1:0]  ex_operand_o,
   output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_o,
   output logic                       stall_o,
   output logic [CNT_W-1:0]           stall_cnt_o
);

   // Tag pipe: entry 0 is EX, entry k is k stages after EX.
   logic [DEPTH-1:0]    tag_valid_r;
   logic [DEPTH-1:0]    tag_wr_r;
   logic [DEPTH-1:0]    tag_mr_r;
   logic [ADDR_W-1:0]   tag_rd_r [DEPTH];

   logic [SEL_W-1:0]    sel_r      [NUM_SRC];
   logic [SEL_W-1:0]    sel_next_s [NUM_SRC];
   logic [NUM_SRC-1:0]  load_hit_s;
   logic                stall_s;
   logic                advance_s;
   logic [CNT_W-1:0]    stall_cnt_r;

   // Youngest matching producer per source; scanning oldest-first lets the lowest k win.
   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         sel_next_s[s] = {SEL_W{1'b0}};
         load_hit_s[s] = 1'b0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (tag_valid_r[k] && tag_wr_r[k] &&
                (tag_rd_r[k] != {ADDR_W{1'b0}}) &&
                (tag_rd_r[k] == id_rs_addr_i[s*ADDR_W +: ADDR_W])) begin
               sel_next_s[s] = SEL_W'(k + 1);
               load_hit_s[s] = (k == 0) && tag_mr_r[k];
            end else begin
               sel_next_s[s] = sel_next_s[s];
               load_hit_s[s] = load_hit_s[s];
            end
         end
      end
   end

   // A flush squashes the ID instruction, so it also cancels any load-use stall.
   assign stall_s   = id_valid_i & ~flush_i & (|load_hit_s);
   assign advance_s = id_valid_i & ~stall_s & ~flush_i;
   assign stall_o   = stall_s;

   // Shift the tag pipe every cycle; entry 0 takes the ID instruction or a bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tag_valid_r <= {DEPTH{1'b0}};
         tag_wr_r    <= {DEPTH{1'b0}};
         tag_mr_r    <= {DEPTH{1'b0}};
         for (int k = 0; k < DEPTH; k++) begin
            tag_rd_r[k] <= {ADDR_W{1'b0}};
         end
      end else begin
         tag_valid_r[0] <= advance_s;
         tag_wr_r[0]    <= advance_s & id_reg_write_i;
         tag_mr_r[0]    <= advance_s & id_mem_read_i;
         tag_rd_r[0]    <= advance_s ? id_rd_addr_i : {ADDR_W{1'b0}};
         for (int k = 1; k < DEPTH; k++) begin
            tag_valid_r[k] <= tag_valid_r[k-1];
            tag_wr_r[k]    <= tag_wr_r[k-1];
            tag_mr_r[k]    <= tag_mr_r[k-1];
            tag_rd_r[k]    <= tag_rd_r[k-1];
         end
      end
   end

   // Register the selects into EX; stalls, flushes and empty slots send a bubble (RF select).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            sel_r[s] <= {SEL_W{1'b0}};
         end
      end else begin
         for (int s = 0; s < NUM_SRC; s++) begin
            sel_r[s] <= advance_s ? sel_next_s[s] : {SEL_W{1'b0}};
         end
      end
   end

   // Count stall cycles, holding at the all-ones value instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt_o = stall_cnt_r;

   // EX operand mux; out-of-range selects fall back to the register file.
   always_comb begin
      ex_operand_o = ex_rf_data_i;
      ex_fwd_sel_o = {(NUM_SRC*SEL_W){1'b0}};
      for (int s = 0; s < NUM_SRC; s++) begin
         ex_fwd_sel_o[s*SEL_W +: SEL_W] = sel_r[s];
         for (int k = 1; k <= DEPTH; k++) begin
            if (sel_r[s] == SEL_W'(k)) begin
               ex_operand_o[s*DATA_W +: DATA_W] = byp_data_i[(k-1)*DATA_W +: DATA_W];
            end else begin
               ex_operand_o[s*DATA_W +: DATA_W] = ex_operand_o[s*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule
